// File: rtl/id_stage.sv
// id_stage: RV32I decode / operand fetch; owns the ID/EX pipeline register.
// Latency: 1 cycle from accept to out_valid; 1 instr/cycle without hazards or stalls.
// Backpressure: ID/EX holds while out_valid && !out_ready; a load-use hazard drops in_ready for one bubble.
module id_stage #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_is_load,
    output logic        out_wen,
    output logic        out_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_X} fmt_e;

    // Everything EX needs from this stage, registered as one word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        is_load;
        logic        wen;
        logic        illegal;
    } idex_t;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    fmt_e        fmt;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        hazard;

    idex_t       idex_d;
    idex_t       idex_q;
    logic        out_valid_d;
    logic        out_valid_q;

    assign opcode = in_instr[6:0];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign rd     = in_instr[11:7];

    // Regfile addresses come straight from the instruction word, valid or not.
    assign rf_rs1 = rs1;
    assign rf_rs2 = rs2;

    // Classify the opcode into an encoding format; unknown opcodes are illegal.
    always_comb begin
        fmt = FMT_X;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            OP_REG:                   fmt = FMT_R;
            default:                  fmt = FMT_X;
        endcase
    end

    assign uses_rs1 = (fmt != FMT_U) && (fmt != FMT_J);
    assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

    // Assemble the sign-extended immediate for the decoded format.
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm = {in_instr[31:12], 12'b0};
            FMT_J:   imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // Operand 1: x0 reads zero, otherwise same-cycle writeback wins over the regfile.
    always_comb begin
        rs1_val = rf_rd1;
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (BYPASS_EN && wb_we && (wb_rd == rs1)) begin
            rs1_val = wb_wd;
        end
    end

    // Operand 2: same selection as operand 1.
    always_comb begin
        rs2_val = rf_rd2;
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (BYPASS_EN && wb_we && (wb_rd == rs2)) begin
            rs2_val = wb_wd;
        end
    end

    // A load in ID/EX cannot forward to the instruction right behind it; hold it one cycle.
    assign hazard = in_valid && out_valid_q && idex_q.is_load && (idex_q.rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == idex_q.rd)) || (uses_rs2 && (rs2 == idex_q.rd)));

    // Flush always drains ID so a killed instruction never blocks fetch.
    assign in_ready = flush || ((!out_valid_q || out_ready) && !hazard);

    // Next ID/EX contents: flush kills, accept loads, drain leaves a bubble, else hold.
    always_comb begin
        idex_d      = idex_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid_d      = 1'b1;
            idex_d.pc        = in_pc;
            idex_d.rs1_val   = rs1_val;
            idex_d.rs2_val   = rs2_val;
            idex_d.imm       = imm;
            idex_d.rs1       = rs1;
            idex_d.rs2       = rs2;
            idex_d.rd        = rd;
            idex_d.opcode    = opcode;
            idex_d.funct3    = in_instr[14:12];
            idex_d.funct7b5  = in_instr[30];
            idex_d.is_load   = (opcode == OP_LOAD);
            idex_d.illegal   = (fmt == FMT_X);
            idex_d.wen       = (fmt != FMT_S) && (fmt != FMT_B) && (fmt != FMT_X) &&
                               (rd != 5'd0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ID/EX register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            idex_q      <= idex_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = idex_q.pc;
    assign out_rs1_val  = idex_q.rs1_val;
    assign out_rs2_val  = idex_q.rs2_val;
    assign out_imm      = idex_q.imm;
    assign out_rs1      = idex_q.rs1;
    assign out_rs2      = idex_q.rs2;
    assign out_rd       = idex_q.rd;
    assign out_opcode   = idex_q.opcode;
    assign out_funct3   = idex_q.funct3;
    assign out_funct7b5 = idex_q.funct7b5;
    assign out_is_load  = idex_q.is_load;
    assign out_wen      = idex_q.wen;
    assign out_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: checks id_stage (bypass on and off) against a behavioural pipeline model.
// Latency: each tick compares in_ready before the edge and all ID/EX outputs 1ns after it.
// Backpressure: out_ready is driven by directed sequences and randomly.
module tb_id_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, wb_we;
    logic [31:0] in_instr, in_pc, rf_rd1, rf_rd2, wb_wd;
    logic [4:0]  wb_rd;

    logic        in_ready, out_valid, out_funct7b5, out_is_load, out_wen, out_illegal;
    logic [4:0]  rf_rs1, rf_rs2, out_rs1, out_rs2, out_rd;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;

    logic        nb_in_ready, nb_out_valid, nb_out_funct7b5, nb_out_is_load, nb_out_wen, nb_out_illegal;
    logic [4:0]  nb_rf_rs1, nb_rf_rs2, nb_out_rs1, nb_out_rs2, nb_out_rd;
    logic [31:0] nb_out_pc, nb_out_rs1_val, nb_out_rs2_val, nb_out_imm;
    logic [6:0]  nb_out_opcode;
    logic [2:0]  nb_out_funct3;

    id_stage #(.BYPASS_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_is_load(out_is_load),
        .out_wen(out_wen), .out_illegal(out_illegal)
    );

    id_stage #(.BYPASS_EN(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nb_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rf_rs1(nb_rf_rs1), .rf_rs2(nb_rf_rs2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .out_valid(nb_out_valid), .out_ready(out_ready), .out_pc(nb_out_pc),
        .out_rs1_val(nb_out_rs1_val), .out_rs2_val(nb_out_rs2_val), .out_imm(nb_out_imm),
        .out_rs1(nb_out_rs1), .out_rs2(nb_out_rs2), .out_rd(nb_out_rd), .out_opcode(nb_out_opcode),
        .out_funct3(nb_out_funct3), .out_funct7b5(nb_out_funct7b5), .out_is_load(nb_out_is_load),
        .out_wen(nb_out_wen), .out_illegal(nb_out_illegal)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int F_I = 0, F_S = 1, F_B = 2, F_U = 3, F_J = 4, F_R = 5, F_X = 6;

    function automatic int fmt_of(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return F_I;
            7'b0100011:                         return F_S;
            7'b1100011:                         return F_B;
            7'b0110111, 7'b0010111:             return F_U;
            7'b1101111:                         return F_J;
            7'b0110011:                         return F_R;
            default:                            return F_X;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        logic signed [31:0] s;
        s = $signed(ins);
        case (fmt_of(ins[6:0]))
            F_I: return 32'(s >>> 20);
            F_S: return 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
            F_B: return 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) |
                        (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            F_U: return ins & 32'hFFFFF000;
            F_J: return 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) |
                        (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] r, input logic [31:0] rf, input bit byp);
        if (r == 5'd0) return 32'd0;
        if (byp && wb_we && wb_rd != 5'd0 && wb_rd == r) return wb_wd;
        return rf;
    endfunction

    typedef struct {
        logic        vld;
        logic [31:0] pc, v1, v2, v1n, v2n, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, ld, wen, ill;
    } mstate_t;

    mstate_t m, mn;
    logic    rdy_seen;

    // One clock: check ID-side combinational outputs, advance model, compare ID/EX.
    task automatic tick();
        int   f;
        logic u1, u2, hz, rdy;
        logic [4:0] r1, r2;
        #1;
        f  = fmt_of(in_instr[6:0]);
        r1 = in_instr[19:15];
        r2 = in_instr[24:20];
        u1 = (f != F_U) && (f != F_J);
        u2 = (f == F_R) || (f == F_S) || (f == F_B);
        hz = in_valid && m.vld && m.ld && (m.rd != 5'd0) &&
             ((u1 && r1 == m.rd) || (u2 && r2 == m.rd));
        rdy = flush || ((!m.vld || out_ready) && !hz);
        rdy_seen = in_ready;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("nb_in_ready", 32'(nb_in_ready), 32'(rdy));
        chk("rf_rs1", 32'(rf_rs1), 32'(r1));
        chk("rf_rs2", 32'(rf_rs2), 32'(r2));
        mn = m;
        if (rst) begin
            mn = '{default: '0};
        end else if (flush) begin
            mn.vld = 1'b0;
        end else if (in_valid && rdy) begin
            mn.vld = 1'b1;
            mn.pc  = in_pc;
            mn.rs1 = r1;
            mn.rs2 = r2;
            mn.rd  = in_instr[11:7];
            mn.op  = in_instr[6:0];
            mn.f3  = in_instr[14:12];
            mn.f7  = in_instr[30];
            mn.imm = imm_of(in_instr);
            mn.ld  = (in_instr[6:0] == 7'b0000011);
            mn.ill = (f == F_X);
            mn.wen = (f != F_S) && (f != F_B) && (f != F_X) && (in_instr[11:7] != 5'd0);
            mn.v1  = opnd(r1, rf_rd1, 1'b1);
            mn.v2  = opnd(r2, rf_rd2, 1'b1);
            mn.v1n = opnd(r1, rf_rd1, 1'b0);
            mn.v2n = opnd(r2, rf_rd2, 1'b0);
        end else if (out_ready) begin
            mn.vld = 1'b0;
        end
        @(posedge clk);
        #1;
        m = mn;
        chk("out_valid", 32'(out_valid), 32'(m.vld));
        chk("out_pc", out_pc, m.pc);
        chk("out_rs1_val", out_rs1_val, m.v1);
        chk("out_rs2_val", out_rs2_val, m.v2);
        chk("out_imm", out_imm, m.imm);
        chk("out_regs", {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, m.rs1, m.rs2, m.rd});
        chk("out_ctrl", {20'd0, out_opcode, out_funct3, out_funct7b5},
                        {20'd0, m.op, m.f3, m.f7});
        chk("out_flags", {29'd0, out_is_load, out_wen, out_illegal}, {29'd0, m.ld, m.wen, m.ill});
        chk("nb_out_rs1_val", nb_out_rs1_val, m.v1n);
        chk("nb_out_rs2_val", nb_out_rs2_val, m.v2n);
        chkw("nb_out_rest",
             {nb_out_valid, nb_out_pc, nb_out_imm, nb_out_rs1, nb_out_rs2, nb_out_rd, nb_out_opcode,
              nb_out_funct3, nb_out_funct7b5, nb_out_is_load, nb_out_wen, nb_out_illegal,
              nb_rf_rs1, nb_rf_rs2},
             {m.vld, m.pc, m.imm, m.rs1, m.rs2, m.rd, m.op, m.f3, m.f7, m.ld, m.wen, m.ill,
              rf_rs1, rf_rs2});
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        rf_rd1   = $urandom;
        rf_rd2   = $urandom;
    endtask

    // Load followed by a candidate consumer; counts stall cycles before it is accepted.
    task automatic load_use(input string nm, input logic [31:0] ld_ins, input logic [31:0] use_ins,
                            input int exp_stalls);
        int   stalls;
        logic acc;
        logic [31:0] ui;
        ui = use_ins;
        out_ready = 1'b1;
        present(ld_ins, 32'h0000_5000);
        tick();
        present(use_ins, 32'h0000_5004);
        stalls = 0;
        acc    = 1'b0;
        for (int c = 0; c < 4 && !acc; c++) begin
            tick();
            if (rdy_seen) begin
                acc = 1'b1;
            end else begin
                stalls++;
                chk({nm, "_bubble"}, 32'(out_valid), 32'd0);
            end
        end
        chk({nm, "_accepted"}, 32'(acc), 32'd1);
        chk({nm, "_stalls"}, stalls, exp_stalls);
        chk({nm, "_rd"}, 32'(out_rd), 32'(ui[11:7]));
        in_valid = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen, ld, ill;
    } vec_t;

    vec_t vt[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{32'h00500093, 32'h00000005, 5'd1,  1'b1, 1'b0, 1'b0}; // addi x1,x0,5
        vt[1]  = '{32'hFE50AE23, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0, 1'b0}; // sw x5,-4(x1)
        vt[2]  = '{32'h0000A103, 32'h00000000, 5'd2,  1'b1, 1'b1, 1'b0}; // lw x2,0(x1)
        vt[3]  = '{32'h123452B7, 32'h12345000, 5'd5,  1'b1, 1'b0, 1'b0}; // lui x5
        vt[4]  = '{32'h002101B3, 32'h00000000, 5'd3,  1'b1, 1'b0, 1'b0}; // add x3,x2,x2
        vt[5]  = '{32'h008000EF, 32'h00000008, 5'd1,  1'b1, 1'b0, 1'b0}; // jal x1,8
        vt[6]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd25, 1'b0, 1'b0, 1'b0}; // beq x1,x2,-8
        vt[7]  = '{32'hFFFFFFFF, 32'h00000000, 5'd31, 1'b0, 1'b0, 1'b1}; // opcode 0x7F
        vt[8]  = '{32'h00100013, 32'h00000001, 5'd0,  1'b0, 1'b0, 1'b0}; // addi x0,x0,1
        vt[9]  = '{32'hFFFFF397, 32'hFFFFF000, 5'd7,  1'b1, 1'b0, 1'b0}; // auipc x7
        vt[10] = '{32'hFFF100E7, 32'hFFFFFFFF, 5'd1,  1'b1, 1'b0, 1'b0}; // jalr x1,-1(x2)

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = 32'h00500093; in_pc = 32'h0; rf_rd1 = 32'h55; rf_rd2 = 32'h66;
        wb_we = 1'b0; wb_rd = 5'd0; wb_wd = 32'h0;
        m = '{default: '0};
        @(posedge clk);
        #1;

        // Reset held with a valid instruction waiting.
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);

        // First accept right after reset: addi x1,x0,5.
        rst = 1'b0;
        present(32'h00500093, 32'h0000_1000);
        tick();
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_rs1_val", out_rs1_val, 32'd0);
        chk("addi_wen", 32'(out_wen), 32'd1);
        chk("addi_illegal", 32'(out_illegal), 32'd0);

        // Decode table, one instruction per cycle.
        foreach (vt[i]) begin
            present(vt[i].ins, 32'h0000_2000 + 32'(i) * 4);
            tick();
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_imm", out_imm, vt[i].imm);
            chk("tbl_rd", 32'(out_rd), 32'(vt[i].rd));
            chk("tbl_flags", {29'd0, out_wen, out_is_load, out_illegal},
                             {29'd0, vt[i].wen, vt[i].ld, vt[i].ill});
        end
        in_valid = 1'b0;
        tick();

        // Store with writeback bypass on rs2.
        present(32'hFE50AE23, 32'h0000_3000);
        rf_rd1 = 32'h100; rf_rd2 = 32'h0;
        wb_we = 1'b1; wb_rd = 5'd5; wb_wd = 32'hDEAD;
        tick();
        wb_we = 1'b0;
        chk("sw_imm", out_imm, 32'hFFFFFFFC);
        chk("sw_rs1_val", out_rs1_val, 32'h100);
        chk("sw_rs2_bypass", out_rs2_val, 32'hDEAD);
        chk("sw_rs2_nobypass", nb_out_rs2_val, 32'h0);
        chk("sw_wen", 32'(out_wen), 32'd0);

        // Load-use cases.
        load_use("lu_dep", 32'h0000A103, 32'h002101B3, 1);
        load_use("lu_x0", 32'h0000A003, 32'h000001B3, 0);
        load_use("lu_indep", 32'h0000A103, 32'h00308233, 0);

        // Backpressure: ID/EX frozen for 3 cycles, then both delivered once each.
        out_ready = 1'b1;
        present(32'h00500093, 32'h0000_6000);
        tick();
        present(32'h002101B3, 32'h0000_6004);
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_in_ready", 32'(rdy_seen), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_pc", out_pc, 32'h0000_6000);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_rdy", 32'(rdy_seen), 32'd1);
        chk("bp_second_pc", out_pc, 32'h0000_6004);
        in_valid = 1'b0;
        tick();
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // Flush during an active load-use stall.
        present(32'h0000A103, 32'h0000_7000);
        tick();
        present(32'h002101B3, 32'h0000_7004);
        flush = 1'b1;
        tick();
        chk("flush_in_ready", 32'(rdy_seen), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("flush_discarded", 32'(out_valid), 32'd0);

        // Reset in the middle of a stall under backpressure.
        out_ready = 1'b1;
        present(32'h0000A103, 32'h0000_8000);
        tick();
        present(32'h002101B3, 32'h0000_8004);
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_stall_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_pc", out_pc, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_stall_ready_after", 32'(rdy_seen), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [6:0] ops [10];
            logic [31:0] ins;
            ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                    7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1111111};
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            present(ins, $urandom);
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            wb_we     = $urandom_range(0, 1);
            wb_rd     = 5'($urandom_range(0, 3));
            wb_wd     = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode/operand-fetch stage of the 5-stage RV32I pipeline. It sits between the IF/ID register and EX, and holds the ID/EX pipeline register. It drives the register file read addresses and decodes immediates and control fields. It also bypasses same-cycle writeback data, detects load-use hazards and inserts one bubble, and supports flush from branch resolution.

## Interface
- BYPASS_EN, default 1: 1 = forward writeback data when the WB write address equals a read address; 0 = raw regfile data.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill the instruction in ID and the ID/EX register
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  ID accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- rf_rs1, rf_rs2  out  5  regfile read addresses = in_instr[19:15], in_instr[24:20] (combinational)
- rf_rd1, rf_rd2  in  32  regfile read data (combinational read)
- wb_we  in  1  writeback write enable (same signal driving the regfile)
- wb_rd  in  5  writeback destination
- wb_wd  in  32  writeback data
- out_valid  out  1  ID/EX holds a valid instruction
- out_ready  in  1  EX accepts ID/EX this cycle
- out_pc, out_rs1_val, out_rs2_val, out_imm  out  32  registered operands and sign-extended immediate
- out_rs1, out_rs2, out_rd  out  5  registered register indices
- out_opcode  out  7; out_funct3  out  3; out_funct7b5  out  1  registered control fields
- out_is_load  out  1  opcode 0000011
- out_wen  out  1  instruction writes rd and rd != 0
- out_illegal  out  1  opcode not in the supported set

## Operation
- Formats by opcode:
  - I: 0000011, 0010011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - R: 0110011
  - Any other opcode: out_illegal=1, out_wen=0, imm=0.
- Immediates (all sign-extended from instr[31]):
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: 0
- Register usage:
  - uses_rs1 = not U and not J.
  - uses_rs2 = R, S or B.
  - out_wen = 0 for S and B, or when rd = 0.
- Bypass (BYPASS_EN=1): operand = wb_wd when wb_we && wb_rd != 0 && wb_rd == rs; otherwise rf_rd. x0 always reads 0.
- hazard = out_valid && out_is_load && out_rd != 0 && ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd)).
  - Only evaluated when in_valid.
- in_ready = flush || ((!out_valid || out_ready) && !hazard).
- ID/EX update, in priority order:
  1. rst: out_valid=0, all out_* = 0.
  2. flush: out_valid=0; the ID instruction is consumed and discarded.
  3. in_valid && in_ready: load all fields, out_valid=1.
  4. out_ready: out_valid=0 (bubble).
  5. Otherwise: hold all fields.
- Bubble semantics: when a hazard stalls while a load is in ID/EX and out_ready=1, the load advances and ID/EX becomes a bubble. Next cycle the hazard clears and the dependent instruction is accepted. EX forwards from MEM.

## Timing
- Latency 1 cycle: accept at edge N, out_valid=1 and fields valid after edge N.
- Throughput 1 instruction/cycle absent hazards and backpressure.
- Load-use costs exactly 1 bubble when out_ready is continuously 1.
- Backpressure (out_valid && !out_ready): ID/EX fields stable, in_ready=0.
- Flush and hazard in the same cycle: flush wins, in_ready=1.
- Flush and WB bypass in the same cycle: flush wins, nothing loaded.
- rst mid-stall: ID/EX cleared on that edge; in_ready=1 the following cycle.
- rf_rs1/rf_rs2 are valid whenever in_instr is stable, independent of in_valid.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, all out_* = 0; first accept occurs the cycle after rst drops.
- Accept 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle out_valid=1, out_rd=1, out_imm=5, out_rs1_val=0, out_wen=1, out_illegal=0.
- Accept 0xFE50AE23 (sw x5,-4(x1)) with rf_rd1=0x100, and wb_we=1, wb_rd=5, wb_wd=0xDEAD while rf_rd2=0 -> out_imm=0xFFFFFFFC, out_rs2_val=0xDEAD, out_wen=0. With BYPASS_EN=0 -> out_rs2_val=0.
- Issue 0x0000A103 (lw x2,0(x1)), then 0x002101B3 (add x3,x2,x2) back to back, out_ready=1 -> in_ready=0 for exactly 1 cycle, one out_valid=0 bubble between them. Replacing rd with x0 or using 0x00308233 -> no bubble.
- Hold out_ready=0 for 3 cycles with the next instruction pending -> ID/EX unchanged, in_ready=0; release -> both instructions delivered in order, none lost or duplicated.
- Assert flush while ID/EX is valid and a load-use stall is active -> next cycle out_valid=0, in_ready=1 during flush, stalled instruction discarded. Opcode 0x7F -> out_illegal=1, out_wen=0.
